// File: rtl/load_store_unit_pkg.sv
// Shared width codes, error causes, FSM states and lane helpers for the load/store unit.
package load_store_unit_pkg;

    // Access width codes carried in width_data_signal_in[1:0].
    localparam logic [1:0] MemWidthByte  = 2'd0;
    localparam logic [1:0] MemWidthHalf  = 2'd1;
    localparam logic [1:0] MemWidthWord  = 2'd2;
    localparam logic [1:0] MemWidthDword = 2'd3;

    typedef enum logic [1:0] {
        CauseNone       = 2'd0,
        CauseMisaligned = 2'd1,
        CauseTimeout    = 2'd2,
        CauseIllegal    = 2'd3
    } err_cause_e;

    typedef enum logic [1:0] {
        StIdle,
        StIssue,
        StDone,
        StErr
    } lsu_state_e;

    // An access is misaligned when any offset bit below its natural size is set.
    function automatic logic is_misaligned(input logic [1:0] width, input logic [2:0] offset);
        logic bad;
        bad = 1'b0;
        case (width)
            MemWidthHalf:  bad = offset[0];
            MemWidthWord:  bad = |offset[1:0];
            MemWidthDword: bad = |offset;
            default:       bad = 1'b0;
        endcase
        return bad;
    endfunction

    // Unshifted byte mask, (2^(2^width))-1.
    function automatic logic [7:0] width_mask(input logic [1:0] width);
        logic [7:0] mask;
        mask = 8'h01;
        case (width)
            MemWidthHalf:  mask = 8'h03;
            MemWidthWord:  mask = 8'h0F;
            MemWidthDword: mask = 8'hFF;
            default:       mask = 8'h01;
        endcase
        return mask;
    endfunction

endpackage

// File: rtl/load_store_unit_align.sv
// Load data alignment: pick the addressed lanes out of the doubleword and extend them.
module load_store_unit_align
    import load_store_unit_pkg::*;
(
    input  logic [63:0] rd_data,
    input  logic [2:0]  offset,
    input  logic [2:0]  width,
    output logic [63:0] load_data
);

    logic [63:0] shifted;
    logic        sext;

    // Shift the addressed byte down to lane 0, truncate, then sign- or zero-extend.
    always_comb begin
        shifted   = rd_data >> {offset, 3'b000};
        sext      = ~width[2];
        load_data = shifted;
        case (width[1:0])
            MemWidthByte:  load_data = {{56{sext & shifted[7]}}, shifted[7:0]};
            MemWidthHalf:  load_data = {{48{sext & shifted[15]}}, shifted[15:0]};
            MemWidthWord:  load_data = {{32{sext & shifted[31]}}, shifted[31:0]};
            MemWidthDword: load_data = shifted;
            default:       load_data = shifted;
        endcase
    end

endmodule

// File: rtl/load_store_unit.sv
// Load/store unit: accepts one memory op at a time, issues it to the data memory
// with a bounded wait for the ack, and reports completion or an error for one cycle.
module load_store_unit
    import load_store_unit_pkg::*;
#(
    parameter int unsigned MAX_WAIT = 16
) (
    input  logic        clk_in,
    input  logic        rst_in,
    input  logic        req_valid_in,
    output logic        req_ready_out,
    input  logic        mem_read_signal_in,
    input  logic        mem_write_signal_in,
    input  logic [2:0]  width_data_signal_in,
    input  logic [63:0] addr_in,
    input  logic [63:0] wr_data_in,
    output logic [63:0] rd_data_out,
    output logic        done_out,
    output logic        error_out,
    output logic [1:0]  error_cause_out,
    output logic        busy_out,
    output logic        dmem_req_out,
    output logic        dmem_we_out,
    output logic [63:0] dmem_addr_out,
    output logic [7:0]  dmem_byte_en_out,
    output logic [63:0] dmem_wr_data_out,
    input  logic        dmem_ack_in,
    input  logic [63:0] dmem_rd_data_in
);

    localparam int unsigned WaitW = $clog2(MAX_WAIT + 1);
    localparam logic [WaitW-1:0] WaitLast = WaitW'(MAX_WAIT - 1);

    lsu_state_e       state_q, state_d;
    err_cause_e       cause_q, cause_d;
    logic [WaitW-1:0] wait_q, wait_d;
    logic [63:0]      rd_data_q, rd_data_d;
    logic [63:0]      addr_q, data_q;
    logic [2:0]       width_q;
    logic             we_q;
    logic             accept;
    logic             in_issue;
    logic [63:0]      load_data;

    load_store_unit_align u_align (
        .rd_data   (dmem_rd_data_in),
        .offset    (addr_q[2:0]),
        .width     (width_q),
        .load_data (load_data)
    );

    // Next-state logic: validate in IDLE, bounded wait in ISSUE, one-cycle DONE/ERR.
    always_comb begin
        state_d   = state_q;
        cause_d   = cause_q;
        wait_d    = wait_q;
        rd_data_d = rd_data_q;
        accept    = 1'b0;
        case (state_q)
            StIdle: begin
                if (req_valid_in) begin
                    if (mem_read_signal_in == mem_write_signal_in) begin
                        state_d = StErr;
                        cause_d = CauseIllegal;
                    end else if (is_misaligned(width_data_signal_in[1:0], addr_in[2:0])) begin
                        state_d = StErr;
                        cause_d = CauseMisaligned;
                    end else begin
                        state_d = StIssue;
                        cause_d = CauseNone;
                        wait_d  = '0;
                        accept  = 1'b1;
                    end
                end
            end
            StIssue: begin
                if (dmem_ack_in) begin
                    state_d = StDone;
                    if (!we_q) begin
                        rd_data_d = load_data;
                    end
                end else if (wait_q == WaitLast) begin
                    state_d = StErr;
                    cause_d = CauseTimeout;
                end else begin
                    wait_d = wait_q + 1'b1;
                end
            end
            StDone:  state_d = StIdle;
            StErr:   state_d = StIdle;
            default: state_d = StIdle;
        endcase
    end

    // State, wait counter, error cause and load result registers.
    always_ff @(posedge clk_in or posedge rst_in) begin
        if (rst_in) begin
            state_q   <= StIdle;
            cause_q   <= CauseNone;
            wait_q    <= '0;
            rd_data_q <= '0;
        end else begin
            state_q   <= state_d;
            cause_q   <= cause_d;
            wait_q    <= wait_d;
            rd_data_q <= rd_data_d;
        end
    end

    // Request capture on acceptance; held stable for the whole ISSUE phase.
    always_ff @(posedge clk_in or posedge rst_in) begin
        if (rst_in) begin
            addr_q  <= '0;
            data_q  <= '0;
            width_q <= '0;
            we_q    <= 1'b0;
        end else if (accept) begin
            addr_q  <= addr_in;
            data_q  <= wr_data_in;
            width_q <= width_data_signal_in;
            we_q    <= mem_write_signal_in;
        end
    end

    // Outputs decoded from state; memory side is zero outside ISSUE.
    always_comb begin
        in_issue         = (state_q == StIssue);
        req_ready_out    = (state_q == StIdle);
        busy_out         = (state_q != StIdle);
        done_out         = (state_q == StDone) || (state_q == StErr);
        error_out        = (state_q == StErr);
        error_cause_out  = (state_q == StErr) ? cause_q : CauseNone;
        rd_data_out      = rd_data_q;
        dmem_req_out     = in_issue;
        dmem_we_out      = in_issue & we_q;
        dmem_addr_out    = in_issue ? {addr_q[63:3], 3'b000} : '0;
        dmem_byte_en_out = in_issue ? (width_mask(width_q[1:0]) << addr_q[2:0]) : '0;
        dmem_wr_data_out = (in_issue && we_q) ? (data_q << {addr_q[2:0], 3'b000}) : '0;
    end

endmodule

// File: doc/load_store_unit.md
LOAD_STORE_UNIT -- requirements
Module: Load_Store_Unit

Interface
REQ-001 SHALL have parameter MAX_WAIT, default 16, the number of ISSUE cycles allowed without dmem_ack_in before a timeout.
REQ-002 SHALL have port clk_in, input, 1, the single clock; all state changes on its rising edge.
REQ-003 SHALL have port rst_in, input, 1, the reset: asynchronous, active-high.
REQ-004 SHALL have port req_valid_in, input, 1, memory-op request from the execute stage.
REQ-005 SHALL have port req_ready_out, output, 1, high only in IDLE.
REQ-006 SHALL have ports mem_read_signal_in and mem_write_signal_in, input, 1 each, the operation select.
REQ-007 SHALL have port width_data_signal_in, input, 3: [1:0] MEM_WIDTH_BYTE/HALF/WORD/DWORD = 0/1/2/3; [2]=1 selects a zero-extended load.
REQ-008 SHALL have port addr_in, input, 64, the byte address (ALU result).
REQ-009 SHALL have port wr_data_in, input, 64, the store data (rs2 value, least-significant bytes used).
REQ-010 SHALL have port rd_data_out, output, 64, the formatted load result.
REQ-011 SHALL have ports done_out (1-cycle completion pulse), error_out (1, with done_out) and error_cause_out (2: 0 none, 1 misaligned, 2 timeout, 3 illegal), all outputs.
REQ-012 SHALL have port busy_out, output, 1, high whenever the state is not IDLE.
REQ-013 SHALL have memory-side outputs dmem_req_out (1), dmem_we_out (1), dmem_addr_out (64, addr_in with [2:0] forced to 0), dmem_byte_en_out (8) and dmem_wr_data_out (64).
REQ-014 SHALL have memory-side inputs dmem_ack_in (1) and dmem_rd_data_in (64, the full aligned doubleword).

Function
REQ-015 SHALL use FSM states IDLE, ISSUE, DONE and ERR.
REQ-016 SHALL accept a request in IDLE when req_valid_in is high and exactly one of mem_read_signal_in or mem_write_signal_in is high, latching address, data, width and operation.
REQ-017 SHALL go IDLE->ERR with cause 3 when req_valid_in is high and both or neither operation signals are high.
REQ-018 SHALL go IDLE->ERR with cause 1 when the access is misaligned: a HALF with addr[0]!=0, a WORD with addr[1:0]!=0, or a DWORD with addr[2:0]!=0; no dmem request is issued.
REQ-019 SHALL hold dmem_req_out high throughout ISSUE, with all dmem outputs stable, until dmem_ack_in.
REQ-020 SHALL go ISSUE->DONE on dmem_ack_in; a load captures the formatted data on that edge.
REQ-021 SHALL go ISSUE->ERR with cause 2 when MAX_WAIT ISSUE cycles pass without an ack; the wait counter clears on each entry to ISSUE.
REQ-022 SHALL pulse done_out for exactly one cycle in DONE or ERR, then return to IDLE; error_out equals (state==ERR).
REQ-023 SHALL take a minimum latency of 2 cycles from acceptance to done_out, when the ack arrives in the first ISSUE cycle.
REQ-024 SHALL form byte enables as (2^(2^width))-1 shifted left by addr[2:0].
REQ-025 SHALL drive store data as wr_data_in shifted left by 8*addr[2:0].
REQ-026 SHALL form a load as dmem_rd_data_in shifted right by 8*addr[2:0], truncated to the width, then sign- or zero-extended per width_data_signal_in[2].
REQ-027 SHALL hold rd_data_out until the next completed load; stores and errors leave it unchanged.
REQ-028 SHALL ignore dmem_ack_in outside ISSUE.
REQ-029 SHALL ignore req_valid_in outside IDLE.

Reset
REQ-030 SHALL, on rst_in, immediately force the state to IDLE, all outputs to 0 except req_ready_out=1, and the wait counter to 0, including an abort of an ISSUE in flight.

Structure
REQ-031 SHALL take the MEM_WIDTH_* codes and error-cause codes from shared Opcodes.vh.
REQ-032 SHALL place byte-lane extraction and extension in one combinational sub-module, Load_Data_Align.

Verification
REQ-033 SHALL verify LB: addr 0x1003, rd_data 0x00000000_80000000 (0x80 in lane 3), ack in the first cycle -> byte_en 0x08, rd_data_out 0xFFFF_FFFF_FFFF_FF80, done_out 2 cycles after acceptance.
REQ-034 SHALL verify LWU: addr 0x1004, rd_data 0x8765_4321_0000_0000 -> rd_data_out 0x0000_0000_8765_4321.
REQ-035 SHALL verify SH: addr 0x2006, wr_data 0xABCD -> byte_en 0xC0, dmem_wr_data 0xABCD_0000_0000_0000, dmem_we_out 1.
REQ-036 SHALL verify a misaligned LW at addr 0x1002 -> no dmem_req_out, done_out with error_out 1, cause 1.
REQ-037 SHALL verify an ack withheld for 16 cycles -> done_out with cause 2; a late ack then arriving in IDLE is ignored.
REQ-038 SHALL verify rst_in asserted mid-ISSUE -> dmem_req_out 0 immediately, IDLE, and a following request completes normally.
